// File: rtl/usb_tx_encoder_pkg.sv
// usb_tx_encoder shared types and constants.
// FSM states, SYNC pattern, stuffing limit and line states.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam logic [2:0] EOP_SE0_BITS = 3'd2;

    // {dplus, dminus}
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Byte handshake between packet assembly and the encoder.
// Master supplies bytes; slave pulses tx_ready on consume.
interface usb_tx_encoder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_encoder_bit_timer.sv
// Bit period timer for the USB transmit encoder.
// Strobes the first and last clock of each bit period.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic bit_start,
    output logic bit_end
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    // Free-running 0..CLKS_PER_BIT-1 while enabled; clear parks it at 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_start = enable && (cnt == '0);
    assign bit_end   = enable && (cnt == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit encoder: SYNC, LSB-first serializer,
// bit stuffing, NRZI line drive and EOP generation.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_tx_encoder_if.slave  tx,
    output logic             dplus_out,
    output logic             dminus_out,
    output logic             tx_active,
    output logic             tx_done,
    output logic             tx_error
);
    tx_state_t  state;
    logic [7:0] sr;
    logic [2:0] ones_cnt;
    logic [2:0] ones_nxt;
    logic [2:0] bit_cnt;
    logic       last_q;
    logic       end_pend;
    logic       nrzi_j;
    logic       tx_ready_q;
    logic       bit_start;
    logic       bit_end;

    usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (state == IDLE),
        .enable    (state != IDLE),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    assign tx.tx_ready = tx_ready_q;
    assign ones_nxt    = sr[0] ? ones_cnt + 3'd1 : 3'd0;

    // Packet FSM: lines are driven at bit start, bookkeeping at bit end.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            sr         <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            last_q     <= 1'b0;
            end_pend   <= 1'b0;
            nrzi_j     <= 1'b1;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            tx_active  <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx.tx_valid) begin
                        sr       <= SYNC_BYTE;
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                        last_q   <= 1'b0;
                        end_pend <= 1'b0;
                        nrzi_j   <= 1'b1;
                        state    <= SYNC;
                    end
                end
                SYNC, DATA: begin
                    if (bit_start) begin
                        tx_active <= 1'b1;
                        // A stuffed bit and a data 0 both toggle.
                        if (ones_cnt == STUFF_LIMIT || !sr[0]) begin
                            nrzi_j <= ~nrzi_j;
                            {dplus_out, dminus_out} <= nrzi_j ? LINE_K : LINE_J;
                        end
                    end
                    if (bit_end) begin
                        if (ones_cnt == STUFF_LIMIT) begin
                            ones_cnt <= '0;
                            if (end_pend) begin
                                state <= EOP_SE0;
                            end
                        end else begin
                            ones_cnt <= ones_nxt;
                            sr       <= {1'b0, sr[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (last_q || !tx.tx_valid) begin
                                    tx_error <= !last_q;
                                    // Final stuff bit goes out before SE0.
                                    if (ones_nxt == STUFF_LIMIT) begin
                                        end_pend <= 1'b1;
                                    end else begin
                                        state <= EOP_SE0;
                                    end
                                end else begin
                                    tx_ready_q <= 1'b1;
                                    sr         <= tx.tx_data;
                                    last_q     <= tx.tx_last;
                                    state      <= DATA;
                                end
                            end
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_start) begin
                        {dplus_out, dminus_out} <= LINE_SE0;
                    end
                    if (bit_end) begin
                        if (bit_cnt == EOP_SE0_BITS - 3'd1) begin
                            bit_cnt <= '0;
                            state   <= EOP_J;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                EOP_J: begin
                    // Second bit start here marks the end of the J period.
                    if (bit_start) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt   <= '0;
                            tx_active <= 1'b0;
                            tx_done   <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            {dplus_out, dminus_out} <= LINE_J;
                            nrzi_j  <= 1'b1;
                            bit_cnt <= 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder.
// Table-driven single-byte packets plus multi-cycle sequences.
module tb_usb_tx_encoder;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic dplus_out, dminus_out, tx_active, tx_done, tx_error;

    always #5 clk = ~clk;

    usb_tx_encoder_if bus();

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx         (bus),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        bit         under;
        string      line;
        int         nerr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    function automatic string sym();
        if (dplus_out && !dminus_out) return "J";
        if (!dplus_out && dminus_out) return "K";
        if (!dplus_out && !dminus_out) return "S";
        return "X";
    endfunction

    // NRZI decode with destuffing; returns byte number nth (0 = SYNC).
    function automatic int decode_nth(input string ln, input int nth);
        string prev;
        string s;
        int ones;
        int nb;
        int val;
        bit b;
        prev = "J";
        ones = 0;
        nb = 0;
        val = 0;
        for (int i = 0; i < ln.len(); i++) begin
            s = ln.substr(i, i);
            if (s == "S") break;
            b = (s == prev);
            prev = s;
            if (ones == 6) begin
                ones = 0;
                continue;
            end
            ones = b ? ones + 1 : 0;
            if (nb / 8 == nth) val = val | (int'(b) << (nb % 8));
            nb++;
        end
        return val;
    endfunction

    task automatic run_pkt(
        input  logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
        input  int n, input bit under,
        output string line, output int cyc, output int nrdy,
        output int nerr, output int ndone, output int act_done,
        output int gap1, output int gap2
    );
        logic [7:0] d[3];
        int rdy_at[4];
        string cs;
        int idx;
        d[0] = d0; d[1] = d1; d[2] = d2;
        rdy_at = '{default: 0};
        cs = ""; line = "";
        idx = 0; cyc = 0; nrdy = 0; nerr = 0; ndone = 0; act_done = -1;
        @(negedge clk);
        bus.tx_data  = d[0];
        bus.tx_last  = (n == 1);
        bus.tx_valid = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (tx_active) begin
                cs = {cs, sym()};
                cyc++;
            end
            if (bus.tx_ready) begin
                if (nrdy < 4) rdy_at[nrdy] = cyc - 1;
                nrdy++;
                idx++;
                if (under || idx >= n) begin
                    bus.tx_valid = 1'b0;
                end else begin
                    bus.tx_data = d[idx];
                    bus.tx_last = (idx == n - 1);
                end
            end
            if (tx_error) nerr++;
            if (tx_done) begin
                ndone++;
                act_done = int'(tx_active);
                break;
            end
        end
        bus.tx_valid = 1'b0;
        for (int k = 0; k * CPB + CPB / 2 < cs.len(); k++) begin
            line = {line, cs.substr(k * CPB + CPB / 2, k * CPB + CPB / 2)};
        end
        gap1 = rdy_at[1] - rdy_at[0];
        gap2 = rdy_at[2] - rdy_at[1];
    endtask

    string sy;
    string line;
    int cyc, nrdy, nerr, ndone, act_done, gap1, gap2;
    int cnt_done, cnt_err, cnt_act;

    initial begin
        sy = "KJKJKJKK";
        vecs[0] = '{8'h00, 1'b0, {sy, "JKJKJKJK", "SSJ"}, 0};
        vecs[1] = '{8'hFF, 1'b0, {sy, "KKKKKJJJJ", "SSJ"}, 0};
        vecs[2] = '{8'hFC, 1'b0, {sy, "JKKKKKKKJ", "SSJ"}, 0};
        vecs[3] = '{8'hA5, 1'b0, {sy, "KJJKJJKK", "SSJ"}, 0};
        vecs[4] = '{8'h7E, 1'b0, {sy, "JJJJJJJKJ", "SSJ"}, 0};
        vecs[5] = '{8'h3F, 1'b0, {sy, "KKKKKJJKJ", "SSJ"}, 0};
        vecs[6] = '{8'h00, 1'b1, {sy, "JKJKJKJK", "SSJ"}, 1};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dplus", int'(dplus_out), 1);
        chk("rst_dminus", int'(dminus_out), 0);
        chk("rst_active", int'(tx_active), 0);
        chk("rst_ready", int'(bus.tx_ready), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_error", int'(tx_error), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Abort a packet partway through SYNC with reset.
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_active", int'(tx_active), 1);
        chk_s("mid_line_k", sym(), "K");
        #2 n_rst = 1'b0;
        #1;
        chk_s("mid_rst_line", sym(), "J");
        chk("mid_rst_active", int'(tx_active), 0);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        cnt_done = 0; cnt_err = 0; cnt_act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt_done += int'(tx_done);
            cnt_err  += int'(tx_error);
            cnt_act  += int'(tx_active);
        end
        chk("mid_no_done", cnt_done, 0);
        chk("mid_no_error", cnt_err, 0);
        chk("mid_idle", cnt_act, 0);

        for (int v = 0; v < 7; v++) begin
            run_pkt(vecs[v].data, 8'h11, 8'h22, vecs[v].under ? 2 : 1,
                    vecs[v].under, line, cyc, nrdy, nerr, ndone,
                    act_done, gap1, gap2);
            chk_s($sformatf("v%0d_line", v), line, vecs[v].line);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].line.len() * CPB);
            chk($sformatf("v%0d_ready", v), nrdy, 1);
            chk($sformatf("v%0d_error", v), nerr, vecs[v].nerr);
            chk($sformatf("v%0d_done", v), ndone, 1);
            chk($sformatf("v%0d_act_fall", v), act_done, 0);
            repeat (2) @(negedge clk);
        end

        run_pkt(8'hA5, 8'h5A, 8'hC3, 3, 1'b0, line, cyc, nrdy, nerr,
                ndone, act_done, gap1, gap2);
        chk("b2b_cycles", cyc, (8 + 24 + 3) * CPB);
        chk("b2b_ready", nrdy, 3);
        chk("b2b_gap1", gap1, 8 * CPB);
        chk("b2b_gap2", gap2, 8 * CPB);
        chk("b2b_sync", decode_nth(line, 0), 8'h80);
        chk("b2b_byte0", decode_nth(line, 1), 8'hA5);
        chk("b2b_byte1", decode_nth(line, 2), 8'h5A);
        chk("b2b_byte2", decode_nth(line, 3), 8'hC3);
        chk("b2b_error", nerr, 0);
        chk("b2b_done", ndone, 1);

        // Next packet requested in the tx_done cycle.
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        chk("next_not_yet", int'(tx_active), 0);
        @(negedge clk);
        chk("next_active", int'(tx_active), 1);
        chk_s("next_first_k", sym(), "K");
        cnt_done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.tx_ready) bus.tx_valid = 1'b0;
            if (tx_done) begin
                cnt_done = 1;
                break;
            end
        end
        bus.tx_valid = 1'b0;
        chk("next_done", cnt_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Full-speed USB 1.1 transmit encoder: the transmit-side counterpart of the receive path's D+ edge detection and NRZI decoding. It accepts packet bytes over a valid/ready handshake and serializes each byte LSB-first. It prepends SYNC, performs bit stuffing, NRZI-encodes the stream onto dplus_out/dminus_out, and terminates each packet with EOP. It sits between the packet-assembly logic (PID/CRC) and the bus pad drivers.

## Interface
- CLKS_PER_BIT, 8, clk cycles per USB bit period (≥2)
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid; in IDLE also starts a packet
- tx_last  in  1  qualifies tx_data as final byte of packet
- tx_ready  out  1  one-cycle pulse: tx_data/tx_last consumed this cycle
- dplus_out  out  1  D+ line drive
- dminus_out  out  1  D- line drive
- tx_active  out  1  high from SYNC start through last EOP J bit
- tx_done  out  1  one-cycle pulse on return to IDLE after a packet
- tx_error  out  1  one-cycle pulse on underrun (packet aborted)

## Operation
- Line states: J = (1,0), K = (0,1), SE0 = (0,0). Idle drives J.
- States: IDLE → SYNC → DATA → EOP_SE0 → EOP_J → IDLE.
- IDLE: tx_valid=1 starts a packet: load shift register with SYNC_BYTE 8'h80, clear ones counter, go to SYNC. This tx_valid is not consumed; tx_ready stays 0.
- Serialization: one bit per bit period, LSB-first.
- NRZI: 0 → toggle line (J↔K); 1 → hold.
- Bit stuffing:
  - ones_cnt increments on each transmitted 1 and clears on 0.
  - When ones_cnt reaches 6, the next bit period carries a stuffed 0 (toggle) and clears ones_cnt. The shift register holds during the stuff bit.
  - Counting spans byte boundaries, including SYNC's final 1.
  - A stuff bit is still inserted when the sixth 1 is the packet's final data bit, before EOP.
- Byte boundary, on the last clock of the 8th bit of the current byte (SYNC or data):
  - Latched last=1 → EOP_SE0, after any pending stuff bit.
  - Else tx_valid=1 → tx_ready=1; load tx_data; latch tx_last; go to or stay in DATA.
  - Else (underrun) → tx_error pulse; go to EOP_SE0 (after any pending stuff bit).
- EOP_SE0: 2 bit periods of SE0. EOP_J: 1 bit period of J. Then IDLE with tx_done pulse.
- tx_valid/tx_data are ignored everywhere except the IDLE start and byte-boundary sampling.

## Timing
- Reset values: dplus_out=1, dminus_out=0, tx_ready=0, tx_active=0, tx_done=0, tx_error=0, state IDLE, counters 0.
- All outputs are registered.
- Line outputs change only at the first clock of a bit period.
- tx_valid sampled high in IDLE at edge N → first SYNC bit (K) and tx_active=1 on the lines after edge N+1.
- Bit timer runs 0..CLKS_PER_BIT-1; it restarts at 0 on packet start and is idle otherwise.
- Packet duration = (8 + 8·nbytes + nstuff + 3) · CLKS_PER_BIT cycles.
- tx_done is asserted in the first IDLE cycle, coincident with tx_active falling. A new packet may start the cycle after that.
- Reset asserted mid-packet: lines return to J immediately (asynchronous). Partial byte discarded; no tx_done or tx_error.

## Structure
- Package usb_tx_pkg holds:
  - state enum (IDLE, SYNC, DATA, EOP_SE0, EOP_J)
  - SYNC_BYTE = 8'h80
  - STUFF_LIMIT = 6
  - EOP_SE0_BITS = 2
  - line-state constants J/K/SE0
- One sub-module, usb_tx_bit_timer: parameter CLKS_PER_BIT; inputs clear/enable; outputs bit_start and bit_end strobes.
- The top level holds the FSM, shift register, ones counter, bit-in-byte counter and NRZI line register.

## Test plan
- Reset: hold n_rst=0 → dplus/dminus = 1/0, all strobes 0. Assert n_rst mid-packet → J within the same cycle, state IDLE.
- Single byte 0x00 with tx_last=1:
  - Line sequence: SYNC K J K J K J K K; then 8 alternating toggles J K J K J K J K; then SE0 SE0 J.
  - Exactly 152 cycles from first K to tx_done; one tx_ready pulse.
- Single byte 0xFF with tx_last=1:
  - SYNC's final 1 plus five data 1s → stuffed 0 after data bit 4.
  - Remaining three 1s hold the line; total 20 bit periods before EOP J ends.
- Last byte 0xFC:
  - Six trailing 1s → stuff bit (toggle) immediately before SE0.
  - Verify ones_cnt clears and EOP still lasts 2+1 bit periods.
- Underrun: two-byte packet with tx_valid low at the first byte's boundary → tx_error pulse, no second tx_ready, EOP follows, tx_done pulses.
- Back-to-back: 3-byte packet 0xA5,0x5A,0xC3 with tx_valid held high → tx_ready pulses exactly 8·CLKS_PER_BIT apart (plus stuff periods). Decoded NRZI stream matches input bytes; a second packet starts the cycle after tx_done.
